mem_io_responder: RTL and testbench
===================================

Name: mem_io_responder

Overview:
- Bus-side responder for the CPU's byte-wide memory port; decodes each cycle's address/write strobe and serves it.
- Block RAM for 0x00000–0x1FFFF.
- Memory-mapped I/O at 0x30000+ (mem_a[17:16]==2'b11):
  - UART tx FIFO with io_buffer_full back-pressure;
  - UART rx byte pop;
  - free-running cycle counter;
  - program-stop flag.
- Sits between the CPU top and the RAM/UART wrappers in the FPGA/sim top.

Parameters:
- ADDR_WIDTH, 17, RAM byte-address width (128 KB).
- TX_DEPTH, 8, tx FIFO entries (power of two, >=4).

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- mem_a  input  32  byte address from CPU; only [17:0] decoded
- mem_wr  input  1  1 = write this cycle, 0 = read
- mem_dout  input  8  write data from CPU
- mem_din  output  8  read data to CPU, registered
- io_buffer_full  output  1  tx FIFO almost full; CPU must not issue I/O writes
- tx_data  output  8  FIFO head byte to UART transmitter
- tx_valid  output  1  FIFO non-empty
- tx_ready  input  1  UART accepts head byte this cycle
- rx_data  input  8  UART receiver head byte
- rx_valid  input  1  rx byte available
- rx_pop  output  1  one-cycle pulse consuming rx byte
- program_stop  output  1  sticky, set by write to 0x30004

Behaviour:
- Decode of mem_a[17:16]:
  - 2'b00, 2'b01: RAM at mem_a[16:0].
  - 2'b10: unmapped; read returns 0x00, write ignored.
  - 2'b11: I/O; mem_a[2:0] selects the register.
- Read latency is exactly 1 cycle: mem_din at edge N+1 reflects the address presented in cycle N. A read in the cycle after a write to the same RAM address returns the new byte.
- Writes take effect at the sampling edge; no wait states; no handshake on the CPU side.
- I/O reads:
  - 0x30000: if rx_valid, return rx_data and pulse rx_pop for that same cycle. Otherwise return 0x00 with no pop.
  - 0x30004–0x30007: return cycle-counter byte mem_a[1:0] (little-endian).
  - Other I/O offsets: return 0x00.
- I/O writes:
  - 0x30000, nonzero byte: push to tx FIFO.
  - 0x30000, 0x00: ignored.
  - 0x30004: set program_stop and push 0x00 (the UART '\0' terminator), regardless of data.
  - Other I/O offsets: ignored.
- Tx FIFO:
  - Push is accepted if count<TX_DEPTH, or if a pop occurs in the same cycle.
  - Push when full with no pop: byte dropped, count unchanged.
  - Pop when tx_valid && tx_ready.
  - Simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo TX_DEPTH.
- io_buffer_full = (count >= TX_DEPTH-1), combinational from count. The one-slot margin covers one write already in flight from the CPU.
- Cycle counter: 32-bit, increments every cycle from 0 after reset, wraps 0xFFFFFFFF→0.
- Reset values:
  - mem_din=0x00, tx FIFO empty (tx_valid=0, io_buffer_full=0), rx_pop=0, program_stop=0, counter=0.
  - RAM contents are not cleared.
- Reset asserted mid-operation overrides any same-cycle push, pop or write. The RAM write in that cycle is still performed.

Optional Feature:
- Macro IO_CNT_SNAPSHOT_EN.
- Defined:
  - A read of 0x30004 returns live byte 0 and copies the full counter into a 32-bit snapshot register.
  - Reads of 0x30005–0x30007 return snapshot bytes 1–3, giving a coherent 4-byte value.
- Undefined: every byte read returns the live counter byte; no snapshot register is built.

Decomposition:
- Shared package/defines:
  - IO_SEL = 2'b11;
  - IO_UART_OFF = 3'd0;
  - IO_CNT_OFF = 3'd4;
  - RAM/unmapped region codes;
  - byte/word width constants.
- One sub-module: io_tx_fifo.
  - Parameterized depth.
  - Ports: push, push_data, pop, head data, empty, count.
  - Implements the simultaneous push/pop and full-drop rules.
- RAM array, decode, counter, rx pop and mem_din register stay in the parent.

Test Plan:
- RAM write/read: write 0xA5 to 0x00123 then read 0x00123 the next cycle → mem_din==0xA5 one cycle after the read address. Read 0x20010 → 0x00.
- UART tx: write 0x41, 0x00, 0x42 to 0x30000 with tx_ready=1 → tx stream 0x41, 0x42 only. Zero-byte write is never pushed.
- Back-pressure: tx_ready=0, push 7 bytes (TX_DEPTH=8) → io_buffer_full=1 after the 7th. 8th push accepted. 9th push dropped, count stays 8. Raise tx_ready → bytes drain in order.
- Stop: write 0xFF to 0x30004 → program_stop=1 (sticky), 0x00 appears on tx_data. Reset → program_stop=0, FIFO empty.
- rx: rx_valid=1, rx_data=0x37, read 0x30000 → mem_din=0x37 and one rx_pop pulse. With rx_valid=0 → 0x00, no pop.
- Counter: 100 cycles after reset, read 0x30004..0x30007 → little-endian count consistent with cycle index. Under IO_CNT_SNAPSHOT_EN, the 4 bytes equal the value at the 0x30004 read. Also force counter 0xFFFFFFFF → wraps to 0.

Source files
------------

// File: rtl/mem_io_responder_pkg.sv
// mem_io_responder_pkg
//   Shared constants and helpers for the CPU memory-port responder:
//   address-region codes for mem_a[17:16], I/O register offsets,
//   byte/word widths, a region decoder and a byte-lane extractor.
package mem_io_responder_pkg;

   localparam int BYTE_W = 8;
   localparam int WORD_W = 32;

   // mem_a[17:16] region codes
   localparam logic [1:0] SEL_RAM_LO = 2'b00;
   localparam logic [1:0] SEL_RAM_HI = 2'b01;
   localparam logic [1:0] SEL_UNMAP  = 2'b10;
   localparam logic [1:0] IO_SEL     = 2'b11;

   // I/O register offsets, mem_a[2:0]
   localparam logic [2:0] IO_UART_OFF = 3'd0;
   localparam logic [2:0] IO_CNT_OFF  = 3'd4;

   typedef enum logic [1:0] {
      RGN_RAM  = 2'd0,
      RGN_NONE = 2'd1,
      RGN_IO   = 2'd2
   } region_e;

   function automatic region_e decode_region(input logic [1:0] sel);
      case (sel)
         SEL_RAM_LO, SEL_RAM_HI: return RGN_RAM;
         SEL_UNMAP:              return RGN_NONE;
         IO_SEL:                 return RGN_IO;
         default:                return RGN_NONE;
      endcase
   endfunction

   // Little-endian byte lane idx of a 32-bit word.
   function automatic logic [BYTE_W-1:0] word_byte(input logic [WORD_W-1:0] w,
                                                    input logic [1:0]        idx);
      return w[{idx, 3'b000} +: BYTE_W];
   endfunction

endpackage

// File: rtl/mem_io_responder_io_tx_fifo.sv
// io_tx_fifo
//   Byte FIFO feeding the UART transmitter.
//   A push is accepted while not full, or when a pop happens in the same
//   cycle (net count unchanged); a push into a full FIFO with no pop is
//   dropped. A pop request is ignored while empty. Pointers wrap modulo
//   DEPTH (DEPTH must be a power of two).
// Ports
//   clk_in, rst_in  clock, synchronous active-high reset
//   push_i          push request, push_data_i byte to store
//   pop_i           pop request (consumer ready)
//   head_o          byte at the head of the queue
//   empty_o         no entries stored
//   count_o         number of stored entries, 0..DEPTH
module io_tx_fifo
   import mem_io_responder_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                     clk_in,
   input  logic                     rst_in,
   input  logic                     push_i,
   input  logic [BYTE_W-1:0]        push_data_i,
   input  logic                     pop_i,
   output logic [BYTE_W-1:0]        head_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [BYTE_W-1:0] mem_q [DEPTH];
   logic [PW-1:0]     wr_ptr_q;
   logic [PW-1:0]     rd_ptr_q;
   logic [CW-1:0]     count_q;
   logic              pop_ok;
   logic              push_ok;

   assign pop_ok  = pop_i && (count_q != '0);
   assign push_ok = push_i && ((count_q < CW'(DEPTH)) || pop_ok);

   always_ff @(posedge clk_in) begin
      if (push_ok && !rst_in) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         case ({push_ok, pop_ok})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign empty_o = (count_q == '0);
   assign count_o = count_q;

endmodule

// File: rtl/mem_io_responder.sv
// mem_io_responder
//   Responder for the CPU byte-wide memory port. Every cycle carries a
//   read or a write; reads return data one cycle later on mem_din.
//     0x00000-0x1FFFF  block RAM (contents survive reset)
//     0x20000-0x2FFFF  unmapped: reads 0x00, writes ignored
//     0x3xxxx          I/O, register chosen by mem_a[2:0]
//        +0  read: pop rx byte (0x00 if none); write: push nonzero byte to tx
//        +4  read +4..+7: cycle counter bytes (little-endian)
//            write +4: set program_stop, push 0x00 terminator to tx
// Build option
//   IO_CNT_SNAPSHOT_EN  a read of +4 captures the whole counter; +5..+7
//                       then return bytes of that capture, so a 4-byte read
//                       sequence is coherent.
// Ports
//   clk_in, rst_in      clock, synchronous active-high reset
//   mem_a, mem_wr, mem_dout   CPU address, write strobe, write data
//   mem_din             registered read data
//   io_buffer_full      tx FIFO has at most one free slot
//   tx_data, tx_valid, tx_ready   tx FIFO head to UART transmitter
//   rx_data, rx_valid, rx_pop     UART receiver head byte and consume pulse
//   program_stop        sticky stop flag
module mem_io_responder
   import mem_io_responder_pkg::*;
#(
   parameter int ADDR_WIDTH = 17,
   parameter int TX_DEPTH   = 8
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic [31:0]       mem_a,
   input  logic              mem_wr,
   input  logic [BYTE_W-1:0] mem_dout,
   output logic [BYTE_W-1:0] mem_din,
   output logic              io_buffer_full,
   output logic [BYTE_W-1:0] tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   input  logic [BYTE_W-1:0] rx_data,
   input  logic              rx_valid,
   output logic              rx_pop,
   output logic              program_stop
);

   localparam int CNT_W = $clog2(TX_DEPTH) + 1;

   logic [ADDR_WIDTH-1:0] ram_addr;
   region_e               region;
   logic [2:0]            io_off;
   logic                  ram_we;
   logic [BYTE_W-1:0]     ram_q [2**ADDR_WIDTH];
   logic [BYTE_W-1:0]     ram_rd_q;
   logic                  rd_ram_q;
   logic [BYTE_W-1:0]     io_rd_d;
   logic [BYTE_W-1:0]     io_rd_q;
   logic [WORD_W-1:0]     cnt_q;
   logic                  stop_q;
   logic                  rx_pop_d;
   logic                  push_d;
   logic [BYTE_W-1:0]     push_data_d;
   logic                  set_stop_d;
   logic [BYTE_W-1:0]     cnt_byte;
   logic                  fifo_empty;
   logic [CNT_W-1:0]      fifo_count;
   logic                  unused_addr_hi;

   assign ram_addr       = mem_a[ADDR_WIDTH-1:0];
   assign region         = decode_region(mem_a[17:16]);
   assign io_off         = mem_a[2:0];
   assign ram_we         = mem_wr && (region == RGN_RAM);
   assign unused_addr_hi = ^mem_a[31:18];

`ifdef IO_CNT_SNAPSHOT_EN
   logic [WORD_W-1:0] snap_q;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         snap_q <= '0;
      end else if ((region == RGN_IO) && !mem_wr && (io_off == IO_CNT_OFF)) begin
         snap_q <= cnt_q;
      end
   end

   // byte 0 is always live: it is the read that takes the snapshot
   assign cnt_byte = (io_off == IO_CNT_OFF) ? word_byte(cnt_q, 2'd0)
                                            : word_byte(snap_q, io_off[1:0]);
`else
   assign cnt_byte = word_byte(cnt_q, io_off[1:0]);
`endif

   always_comb begin
      io_rd_d     = '0;
      rx_pop_d    = 1'b0;
      push_d      = 1'b0;
      push_data_d = '0;
      set_stop_d  = 1'b0;
      if (region == RGN_IO) begin
         if (!mem_wr) begin
            if (io_off == IO_UART_OFF) begin
               if (rx_valid) begin
                  io_rd_d  = rx_data;
                  rx_pop_d = 1'b1;
               end
            end else if (io_off >= IO_CNT_OFF) begin
               io_rd_d = cnt_byte;
            end
         end else if (io_off == IO_UART_OFF) begin
            // zero bytes are reserved for the stop terminator
            push_d      = (mem_dout != '0);
            push_data_d = mem_dout;
         end else if (io_off == IO_CNT_OFF) begin
            push_d     = 1'b1;
            set_stop_d = 1'b1;
         end
      end
   end

   // RAM is written even during reset; the read port is registered so the
   // array maps onto block RAM, and the array is updated at the same edge
   // so a read in the following cycle sees the new byte.
   always_ff @(posedge clk_in) begin
      if (ram_we) begin
         ram_q[ram_addr] <= mem_dout;
      end
      ram_rd_q <= ram_q[ram_addr];
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         rd_ram_q <= 1'b0;
         io_rd_q  <= '0;
         cnt_q    <= '0;
         stop_q   <= 1'b0;
      end else begin
         rd_ram_q <= !mem_wr && (region == RGN_RAM);
         io_rd_q  <= io_rd_d;
         cnt_q    <= cnt_q + 32'd1;
         if (set_stop_d) begin
            stop_q <= 1'b1;
         end
      end
   end

   assign mem_din      = rd_ram_q ? ram_rd_q : io_rd_q;
   assign rx_pop       = rx_pop_d && !rst_in;
   assign program_stop = stop_q;

   io_tx_fifo #(
      .DEPTH (TX_DEPTH)
   ) u_tx_fifo (
      .clk_in      (clk_in),
      .rst_in      (rst_in),
      .push_i      (push_d),
      .push_data_i (push_data_d),
      .pop_i       (tx_ready),
      .head_o      (tx_data),
      .empty_o     (fifo_empty),
      .count_o     (fifo_count)
   );

   assign tx_valid       = !fifo_empty;
   // one spare slot absorbs a write the CPU already has in flight
   assign io_buffer_full = (fifo_count >= CNT_W'(TX_DEPTH - 1));

endmodule

// File: tb/tb_mem_io_responder.sv
module tb_mem_io_responder;

   localparam int DEPTH = 8;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b1;
   logic [31:0] mem_a = 32'h0002_0000;
   logic        mem_wr = 1'b0;
   logic [7:0]  mem_dout = 8'h00;
   logic [7:0]  mem_din;
   logic        io_buffer_full;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        rx_pop;
   logic        program_stop;

   mem_io_responder #(.ADDR_WIDTH(17), .TX_DEPTH(DEPTH)) dut (
      .clk_in         (clk_in),
      .rst_in         (rst_in),
      .mem_a          (mem_a),
      .mem_wr         (mem_wr),
      .mem_dout       (mem_dout),
      .mem_din        (mem_din),
      .io_buffer_full (io_buffer_full),
      .tx_data        (tx_data),
      .tx_valid       (tx_valid),
      .tx_ready       (tx_ready),
      .rx_data        (rx_data),
      .rx_valid       (rx_valid),
      .rx_pop         (rx_pop),
      .program_stop   (program_stop)
   );

   always #5 clk_in = ~clk_in;

   int checks = 0;
   int failures = 0;

   // reference model state
   logic [7:0]  ram_m [int];
   logic [7:0]  tx_q [$];
   logic        stop_m = 1'b0;
   logic [31:0] cyc_m = 32'd0;
   logic [31:0] snap_m = 32'd0;
   logic [7:0]  txcap [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] cbyte(input logic [31:0] w, input int idx);
      return 8'((w >> (8 * idx)) & 32'hFF);
   endfunction

   // Expected read data for a read in the current cycle; known=0 when the
   // RAM byte was never written.
   function automatic logic [7:0] model_read(input logic [31:0] a, input logic rxv,
                                             input logic [7:0] rxd, output logic known);
      int la;
      int off;
      la = int'(a[17:0]);
      off = la % 8;
      known = 1'b1;
      if (la < 'h20000) begin
         if (ram_m.exists(la)) return ram_m[la];
         known = 1'b0;
         return 8'h00;
      end
      if (la < 'h30000) return 8'h00;
      if (off == 0) return rxv ? rxd : 8'h00;
      if (off >= 4) begin
`ifdef IO_CNT_SNAPSHOT_EN
         if (off == 4) return cbyte(cyc_m, 0);
         return cbyte(snap_m, off - 4);
`else
         return cbyte(cyc_m, off - 4);
`endif
      end
      return 8'h00;
   endfunction

   // One bus cycle: drive at negedge, check combinational outputs, update
   // the model, check registered outputs after the edge, return at negedge.
   task automatic step(input logic [31:0] a, input logic wr, input logic [7:0] d,
                       input logic rxv, input logic [7:0] rxd, input logic txr,
                       input logic rst, output logic [7:0] din_o, output logic pop_o);
      logic [7:0] exp_din;
      logic       known;
      logic       exp_pop;
      logic       is_push;
      logic [7:0] push_d;
      logic       do_pop;
      int         sz;
      int         la;
      int         off;
      mem_a = a; mem_wr = wr; mem_dout = d;
      rx_valid = rxv; rx_data = rxd; tx_ready = txr; rst_in = rst;
      #1;
      la = int'(a[17:0]);
      off = la % 8;
      chk("tx_valid", 32'(tx_valid), 32'(tx_q.size() != 0));
      if (tx_q.size() != 0) chk("tx_data", 32'(tx_data), 32'(tx_q[0]));
      chk("buf_full", 32'(io_buffer_full), 32'(tx_q.size() >= DEPTH - 1));
      exp_pop = !rst && !wr && (la >= 'h30000) && (off == 0) && rxv;
      chk("rx_pop", 32'(rx_pop), 32'(exp_pop));
      pop_o = rx_pop;
      if (!rst && txr && tx_valid) txcap.push_back(tx_data);
      exp_din = model_read(a, rxv, rxd, known);
      if (wr && la < 'h20000) ram_m[la] = d;
      if (rst) begin
         tx_q.delete();
         stop_m = 1'b0;
         cyc_m = 32'd0;
         snap_m = 32'd0;
      end else begin
         do_pop = (tx_q.size() != 0) && txr;
         is_push = 1'b0;
         push_d = 8'h00;
         if (wr && la >= 'h30000) begin
            if (off == 0 && d != 8'h00) begin is_push = 1'b1; push_d = d; end
            if (off == 4) begin is_push = 1'b1; push_d = 8'h00; stop_m = 1'b1; end
         end
         if (!wr && la >= 'h30000 && off == 4) snap_m = cyc_m;
         sz = tx_q.size();
         if (do_pop) void'(tx_q.pop_front());
         if (is_push && (sz < DEPTH || do_pop)) tx_q.push_back(push_d);
         cyc_m = cyc_m + 32'd1;
      end
      @(posedge clk_in);
      #1;
      din_o = mem_din;
      if (rst) chk("din_rst", 32'(mem_din), 32'h0);
      else if (!wr && known) chk("mem_din", 32'(mem_din), 32'(exp_din));
      chk("stop", 32'(program_stop), 32'(stop_m));
      @(negedge clk_in);
   endtask

   logic [7:0] din;
   logic       pop;

   task automatic wr_b(input logic [31:0] a, input logic [7:0] d, input logic txr);
      step(a, 1'b1, d, 1'b0, 8'h00, txr, 1'b0, din, pop);
   endtask

   task automatic rd_b(input logic [31:0] a, input logic txr);
      step(a, 1'b0, 8'h00, 1'b0, 8'h00, txr, 1'b0, din, pop);
   endtask

   task automatic idle(input int n, input logic txr);
      for (int i = 0; i < n; i++) rd_b(32'h0002_0000, txr);
   endtask

   task automatic do_reset();
      step(32'h0002_0000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, din, pop);
   endtask

   typedef struct {
      logic [31:0] a;
      logic        wr;
      logic [7:0]  d;
      logic        rxv;
      logic [7:0]  rxd;
      logic        chk_din;
      logic [7:0]  exp_din;
      logic        exp_pop;
   } vec_t;

   vec_t vt [14];
   logic [31:0] pool [5];

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0]  = '{32'h0000_0123, 1'b1, 8'hA5, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
      vt[1]  = '{32'h0000_0123, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'hA5, 1'b0};
      vt[2]  = '{32'h0002_0010, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0};
      vt[3]  = '{32'h0001_FFFF, 1'b1, 8'h3C, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
      vt[4]  = '{32'h0001_FFFF, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h3C, 1'b0};
      vt[5]  = '{32'h0001_0000, 1'b1, 8'h81, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
      vt[6]  = '{32'h0001_0000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h81, 1'b0};
      vt[7]  = '{32'hFFFC_0123, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'hA5, 1'b0};
      vt[8]  = '{32'h0003_0000, 1'b0, 8'h00, 1'b1, 8'h37, 1'b1, 8'h37, 1'b1};
      vt[9]  = '{32'h0003_0000, 1'b0, 8'h00, 1'b0, 8'h37, 1'b1, 8'h00, 1'b0};
      vt[10] = '{32'h0003_0001, 1'b0, 8'h00, 1'b1, 8'h44, 1'b1, 8'h00, 1'b0};
      vt[11] = '{32'h0002_0010, 1'b1, 8'h77, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
      vt[12] = '{32'h0002_0010, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0};
      vt[13] = '{32'h0003_0008, 1'b0, 8'h00, 1'b1, 8'h5A, 1'b1, 8'h5A, 1'b1};

      @(negedge clk_in);
      do_reset();
      do_reset();
      chk("rst_din", 32'(mem_din), 32'h00);
      chk("rst_txv", 32'(tx_valid), 32'h0);
      chk("rst_full", 32'(io_buffer_full), 32'h0);
      chk("rst_stop", 32'(program_stop), 32'h0);

      // table-driven RAM / unmapped / rx vectors
      for (int i = 0; i < 14; i++) begin
         step(vt[i].a, vt[i].wr, vt[i].d, vt[i].rxv, vt[i].rxd, 1'b1, 1'b0, din, pop);
         if (vt[i].chk_din) chk($sformatf("vec%0d_din", i), 32'(din), 32'(vt[i].exp_din));
         chk($sformatf("vec%0d_pop", i), 32'(pop), 32'(vt[i].exp_pop));
      end

      // UART tx: zero byte never pushed
      do_reset();
      txcap.delete();
      wr_b(32'h0003_0000, 8'h41, 1'b1);
      wr_b(32'h0003_0000, 8'h00, 1'b1);
      wr_b(32'h0003_0000, 8'h42, 1'b1);
      idle(3, 1'b1);
      chk("uart_len", 32'(txcap.size()), 32'd2);
      if (txcap.size() == 2) begin
         chk("uart_b0", 32'(txcap[0]), 32'h41);
         chk("uart_b1", 32'(txcap[1]), 32'h42);
      end

      // back-pressure and full drop
      do_reset();
      for (int i = 1; i <= 7; i++) begin
         wr_b(32'h0003_0000, 8'(i), 1'b0);
         if (i == 6) chk("bp_full6", 32'(io_buffer_full), 32'h0);
         if (i == 7) chk("bp_full7", 32'(io_buffer_full), 32'h1);
      end
      wr_b(32'h0003_0000, 8'h08, 1'b0);
      wr_b(32'h0003_0000, 8'h09, 1'b0);
      chk("bp_head", 32'(tx_data), 32'h01);
      txcap.delete();
      idle(10, 1'b1);
      chk("bp_len", 32'(txcap.size()), 32'd8);
      for (int i = 0; i < txcap.size(); i++) chk($sformatf("bp_b%0d", i), 32'(txcap[i]), 32'(i + 1));
      chk("bp_empty", 32'(tx_valid), 32'h0);

      // full FIFO: push with simultaneous pop is accepted
      do_reset();
      for (int i = 0; i < 8; i++) wr_b(32'h0003_0000, 8'(8'h11 + i), 1'b0);
      txcap.delete();
      wr_b(32'h0003_0000, 8'h99, 1'b1);
      idle(10, 1'b1);
      chk("pp_len", 32'(txcap.size()), 32'd9);
      if (txcap.size() == 9) chk("pp_last", 32'(txcap[8]), 32'h99);

      // program stop
      do_reset();
      wr_b(32'h0003_0004, 8'hFF, 1'b0);
      chk("stop_set", 32'(program_stop), 32'h1);
      chk("stop_txv", 32'(tx_valid), 32'h1);
      chk("stop_txd", 32'(tx_data), 32'h00);
      idle(3, 1'b1);
      chk("stop_sticky", 32'(program_stop), 32'h1);
      wr_b(32'h0003_0000, 8'h61, 1'b0);
      do_reset();
      chk("stop_clr", 32'(program_stop), 32'h0);
      chk("stop_txclr", 32'(tx_valid), 32'h0);
      chk("stop_fullclr", 32'(io_buffer_full), 32'h0);

      // reset overrides push; RAM write still lands
      step(32'h0000_0200, 1'b1, 8'h5E, 1'b0, 8'h00, 1'b0, 1'b1, din, pop);
      step(32'h0003_0000, 1'b1, 8'h55, 1'b0, 8'h00, 1'b1, 1'b1, din, pop);
      chk("rst_nopush", 32'(tx_valid), 32'h0);
      rd_b(32'h0000_0200, 1'b0);
      chk("rst_ramwr", 32'(din), 32'h5E);

      // counter after 100 idle cycles
      do_reset();
      idle(100, 1'b0);
      rd_b(32'h0003_0004, 1'b0);
      chk("cnt_b0", 32'(din), 32'd100);
      rd_b(32'h0003_0005, 1'b0);
      chk("cnt_b1", 32'(din), 32'h00);
      rd_b(32'h0003_0006, 1'b0);
      rd_b(32'h0003_0007, 1'b0);

      // counter wrap
      force dut.cnt_q = 32'hFFFF_FFFF;
      idle(1, 1'b0);
      release dut.cnt_q;
      cyc_m = 32'hFFFF_FFFF;
      rd_b(32'h0003_0004, 1'b0);
      chk("wrap_b0", 32'(din), 32'hFF);
      rd_b(32'h0003_0007, 1'b0);
`ifdef IO_CNT_SNAPSHOT_EN
      chk("wrap_b3", 32'(din), 32'hFF);
`else
      chk("wrap_b3", 32'(din), 32'h00);
`endif
      rd_b(32'h0003_0004, 1'b0);
      chk("wrap_next", 32'(din), 32'h01);

      // randomized traffic against the reference model
      pool[0] = 32'h0000_0123; pool[1] = 32'h0001_FFFF; pool[2] = 32'h0001_0000;
      pool[3] = 32'h0000_0200; pool[4] = 32'h0000_ABCD;
      for (int i = 0; i < 5; i++) wr_b(pool[i], 8'($urandom), 1'b1);
      for (int n = 0; n < 600; n++) begin
         int          k;
         logic [31:0] r;
         logic [31:0] a;
         logic        txr;
         logic [7:0]  d;
         k = int'($urandom_range(0, 9));
         r = $urandom;
         txr = 1'($urandom_range(0, 1));
         d = 8'($urandom);
         case (k)
            0, 1: begin a = pool[$urandom_range(0, 4)]; a[31:18] = r[31:18]; wr_b(a, d, txr); end
            2, 3: begin a = pool[$urandom_range(0, 4)]; a[31:18] = r[31:18]; rd_b(a, txr); end
            4: step({r[31:18], 2'b10, r[15:0]}, r[17], d, 1'b0, 8'h00, txr, 1'b0, din, pop);
            5: step({r[31:18], 2'b11, r[15:3], 3'd0}, 1'b0, 8'h00, r[16], d, txr, 1'b0, din, pop);
            6: rd_b({r[31:18], 2'b11, r[15:3], 1'b1, r[1:0]}, txr);
            7: wr_b(32'h0003_0000, (r[1:0] == 2'b00) ? 8'h00 : d, txr);
            8: begin
               if (r[5:0] == 6'd0) wr_b(32'h0003_0004, d, txr);
               else step({16'h0003, 13'h0, 3'(1 + (r[7:4] % 3))}, r[8], d, 1'b1, d, txr, 1'b0, din, pop);
            end
            default: begin
               if (r[3:0] == 4'd0) do_reset();
               else idle(1, txr);
            end
         endcase
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
